// File: rtl/sram_port_driver_pkg.sv
// Shared widths, FSM encoding and strobe constants for the SRAM port driver.
package sram_port_driver_pkg;

    localparam int WORD_W      = 16;  // MemValue width
    localparam int CPU_ADDR_W  = 16;  // MemAddr width
    localparam int SRAM_ADDR_W = 18;  // external SRAM address pins
    localparam int CNT_W       = 4;   // holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15

    // Active-low strobes rest high.
    localparam logic STROBE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/sram_port_driver.sv
// Per-chip asynchronous SRAM sequencer. Accepts one request from the arbiter,
// runs a SETUP / ACCESS(xWAIT_CYCLES) / DONE cycle on the pins and pulses
// work_done. Pin strobes are decoded from the current state and registered,
// so the pins follow the state register by one clock; this places work_done
// WAIT_CYCLES+2 edges after the accepting edge, and the FSM is already back
// in IDLE when work_done rises, so the next request is sampled one edge later.
module sram_port_driver
    import sram_port_driver_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   need_to_work,
    input  logic                   mem_rd,
    input  logic                   mem_wr,
    input  logic [CPU_ADDR_W-1:0]  addr,
    input  logic [WORD_W-1:0]      wdata,
    output logic                   work_done,
    output logic [WORD_W-1:0]      feedback,
    output logic [SRAM_ADDR_W-1:0] ram_addr,
    inout  wire  [WORD_W-1:0]      ram_data,
    output logic                   ram_en,
    output logic                   ram_oe,
    output logic                   ram_we
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    op_t                   op_q;
    logic [CPU_ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0]     wdata_q;
    logic                  drive_q;

    logic accept, capture;
    logic en_d, oe_d, we_d, drive_d, done_d;

    // Next state, counter and next pin values decoded from the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        en_d    = STROBE_IDLE;
        oe_d    = STROBE_IDLE;
        we_d    = STROBE_IDLE;
        drive_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (need_to_work && (mem_rd || mem_wr)) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                en_d    = 1'b0;
                oe_d    = (op_q == OP_WRITE);
                drive_d = (op_q == OP_WRITE);
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                en_d = 1'b0;
                if (op_q == OP_WRITE) begin
                    we_d    = 1'b0;
                    drive_d = 1'b1;
                end else begin
                    oe_d = 1'b0;
                end
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    capture = (op_q == OP_READ);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                // Keep write data on the bus one more cycle as hold time.
                drive_d = (op_q == OP_WRITE);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and strobe-width counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latch on acceptance; read data capture on the last ACCESS edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            feedback <= '0;
        end else begin
            if (accept) begin
                op_q    <= mem_wr ? OP_WRITE : OP_READ;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (capture) begin
                feedback <= ram_data;
            end
        end
    end

    // Registered pin strobes, bus drive enable and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en    <= STROBE_IDLE;
            ram_oe    <= STROBE_IDLE;
            ram_we    <= STROBE_IDLE;
            drive_q   <= 1'b0;
            work_done <= 1'b0;
        end else begin
            ram_en    <= en_d;
            ram_oe    <= oe_d;
            ram_we    <= we_d;
            drive_q   <= drive_d;
            work_done <= done_d;
        end
    end

    assign ram_addr = {{(SRAM_ADDR_W - CPU_ADDR_W){1'b0}}, addr_q};
    assign ram_data = drive_q ? wdata_q : {WORD_W{1'bz}};

endmodule

// File: tb/tb_sram_port_driver.sv
// Bench for sram_port_driver: two instances (WAIT_CYCLES 1 and 3), each with
// an SRAM pin model, checked against a memory/feedback reference model.
module tb_sram_port_driver;

    localparam int W0 = 1;
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ntw [2], rd [2], wr [2], done [2], en [2], oe [2], we [2], probe_en [2];
    logic [15:0] a_in [2], d_in [2], fb [2];
    logic [17:0] radr [2];
    wire  [15:0] bus0, bus1;

    logic [15:0] sram    [2][65536];
    logic [15:0] ref_mem [2][65536];
    logic [15:0] ref_fb  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_port_driver #(.WAIT_CYCLES(W0)) u0 (
        .clk(clk), .rst(rst), .need_to_work(ntw[0]), .mem_rd(rd[0]), .mem_wr(wr[0]),
        .addr(a_in[0]), .wdata(d_in[0]), .work_done(done[0]), .feedback(fb[0]),
        .ram_addr(radr[0]), .ram_data(bus0), .ram_en(en[0]), .ram_oe(oe[0]), .ram_we(we[0])
    );

    sram_port_driver #(.WAIT_CYCLES(W1)) u1 (
        .clk(clk), .rst(rst), .need_to_work(ntw[1]), .mem_rd(rd[1]), .mem_wr(wr[1]),
        .addr(a_in[1]), .wdata(d_in[1]), .work_done(done[1]), .feedback(fb[1]),
        .ram_addr(radr[1]), .ram_data(bus1), .ram_en(en[1]), .ram_oe(oe[1]), .ram_we(we[1])
    );

    // SRAM read path, plus a zero-driving probe used to see whether the DUT has released the bus.
    assign bus0 = (!en[0] && !oe[0]) ? sram[0][radr[0][15:0]] : 16'hzzzz;
    assign bus1 = (!en[1] && !oe[1]) ? sram[1][radr[1][15:0]] : 16'hzzzz;
    assign bus0 = probe_en[0] ? 16'h0000 : 16'hzzzz;
    assign bus1 = probe_en[1] ? 16'h0000 : 16'hzzzz;

    // SRAM write path: the word is taken mid-cycle while the write strobe is low.
    always @(negedge clk) begin
        if (rst && !en[0] && !we[0]) sram[0][radr[0][15:0]] = bus0;
        if (rst && !en[1] && !we[1]) sram[1][radr[1][15:0]] = bus1;
    end

    function automatic logic [15:0] busv(input int i);
        return (i == 0) ? bus0 : bus1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int i, input logic r, input logic w,
                             input logic [15:0] a, input logic [15:0] d);
        ntw[i]  = 1'b1;
        rd[i]   = r;
        wr[i]   = w;
        a_in[i] = a;
        d_in[i] = d;
    endtask

    // Follows one access from its accepting edge to work_done and checks it
    // against the reference rules; then updates the reference model.
    task automatic observe(input int i, input int wc, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input bit drop, input bit keep,
                           output int t_done);
        int lat = -1;
        int en_lo = 0, oe_lo = 0, we_lo = 0, bus_bad = 0, addr_bad = 0, extra = 0;
        logic [15:0] exp_fb;
        exp_fb = w ? ref_fb[i] : ref_mem[i][a];
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (drop && c == 1) begin
                ntw[i]  = 1'b0;
                a_in[i] = 16'h0000;
                d_in[i] = ~d;
            end
            if (!en[i]) begin
                en_lo++;
                if (radr[i] !== {2'b00, a}) addr_bad++;
            end
            if (!oe[i]) begin
                oe_lo++;
                if (busv(i) !== ref_mem[i][a]) bus_bad++;
            end
            if (!we[i]) we_lo++;
            if (w && c >= 1 && c <= wc + 2 && busv(i) !== d) bus_bad++;
            if (done[i]) begin
                lat = c;
                break;
            end
        end
        t_done = cyc;
        chk("latency", lat, wc + 2);
        chk("en_low_cycles", en_lo, wc + 1);
        chk("oe_low_cycles", oe_lo, w ? 0 : wc + 1);
        chk("we_low_cycles", we_lo, w ? wc : 0);
        chk("ram_addr", addr_bad, 0);
        chk(w ? "write_bus" : "read_bus", bus_bad, 0);
        chk("feedback", fb[i], exp_fb);
        if (w) ref_mem[i][a] = d;
        else   ref_fb[i] = exp_fb;
        if (!keep) begin
            ntw[i] = 1'b0;
            rd[i]  = 1'b0;
            wr[i]  = 1'b0;
            repeat (3) begin
                @(negedge clk);
                probe_en[i] = 1'b1;
                #1;
                if (done[i] || !en[i] || busv(i) !== 16'h0000) extra++;
                probe_en[i] = 1'b0;
            end
            chk("idle_after_done", extra, 0);
        end
    endtask

    initial begin
        logic [15:0] v, a, d;
        logic [15:0] last_a [2];
        int t1, t2, i, sel, cnt;
        bit w, r, drop;

        for (int k = 0; k < 2; k++) begin
            ntw[k] = 0; rd[k] = 0; wr[k] = 0; a_in[k] = 0; d_in[k] = 0;
            ref_fb[k] = 0; probe_en[k] = 0; last_a[k] = 16'h0000;
            for (int j = 0; j < 65536; j++) begin
                v = 16'($urandom);
                sram[k][j]    = v;
                ref_mem[k][j] = v;
            end
        end

        // Reset held with a pending write: pins idle, outputs cleared.
        #1 rst = 1'b0;
        drive_req(0, 1'b0, 1'b1, 16'h8005, 16'hBEEF);
        repeat (3) @(negedge clk);
        probe_en[0] = 1'b1;
        #1;
        chk("rst_en", en[0], 1);
        chk("rst_oe", oe[0], 1);
        chk("rst_we", we[0], 1);
        chk("rst_done", done[0], 0);
        chk("rst_feedback", fb[0], 0);
        chk("rst_ram_addr", radr[0], 0);
        chk("rst_bus_released", bus0, 16'h0000);
        probe_en[0] = 1'b0;

        // Release: the held write is accepted on the next edge.
        rst = 1'b1;
        observe(0, W0, 1'b1, 16'h8005, 16'hBEEF, 1'b0, 1'b0, t1);
        chk("wr_pins_8005", sram[0][16'h8005], 16'hBEEF);

        // Read it back.
        drive_req(0, 1'b1, 1'b0, 16'h8005, 16'h0000);
        observe(0, W0, 1'b0, 16'h8005, 16'h0000, 1'b0, 1'b0, t1);
        chk("rd_beef", fb[0], 16'hBEEF);

        // Both qualifiers: write wins, feedback untouched.
        drive_req(0, 1'b1, 1'b1, 16'h0123, 16'h1234);
        observe(0, W0, 1'b1, 16'h0123, 16'h1234, 1'b0, 1'b0, t1);
        chk("prio_fb_kept", fb[0], 16'hBEEF);
        drive_req(0, 1'b1, 1'b0, 16'h0123, 16'h0000);
        observe(0, W0, 1'b0, 16'h0123, 16'h0000, 1'b0, 1'b0, t1);

        // Request dropped and address changed mid-access.
        drive_req(0, 1'b0, 1'b1, 16'h4444, 16'h5A5A);
        observe(0, W0, 1'b1, 16'h4444, 16'h5A5A, 1'b1, 1'b0, t1);
        drive_req(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        observe(0, W0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, t1);
        drive_req(0, 1'b1, 1'b0, 16'h4444, 16'h0000);
        observe(0, W0, 1'b0, 16'h4444, 16'h0000, 1'b0, 1'b0, t1);

        // need_to_work without rd/wr: no pin activity.
        drive_req(0, 1'b0, 1'b0, 16'h1111, 16'h2222);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (!en[0] || done[0]) cnt++;
        end
        chk("no_op_idle", cnt, 0);
        ntw[0] = 1'b0;
        @(negedge clk);

        // Back-to-back reads with need_to_work held high.
        sram[0][16'h00A1] = 16'hA1A1; ref_mem[0][16'h00A1] = 16'hA1A1;
        sram[0][16'h00B2] = 16'hB2B2; ref_mem[0][16'h00B2] = 16'hB2B2;
        drive_req(0, 1'b1, 1'b0, 16'h00A1, 16'h0000);
        observe(0, W0, 1'b0, 16'h00A1, 16'h0000, 1'b0, 1'b1, t1);
        chk("b2b_fb1", fb[0], 16'hA1A1);
        drive_req(0, 1'b1, 1'b0, 16'h00B2, 16'h0000);
        observe(0, W0, 1'b0, 16'h00B2, 16'h0000, 1'b0, 1'b0, t2);
        chk("b2b_fb2", fb[0], 16'hB2B2);
        chk("b2b_spacing", t2 - t1, W0 + 3);

        // Longer strobe instance: read then write then read.
        drive_req(1, 1'b1, 1'b0, 16'h3C3C, 16'h0000);
        observe(1, W1, 1'b0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, t1);
        drive_req(1, 1'b0, 1'b1, 16'h3C3C, 16'h9876);
        observe(1, W1, 1'b1, 16'h3C3C, 16'h9876, 1'b0, 1'b0, t1);
        drive_req(1, 1'b1, 1'b0, 16'h3C3C, 16'h0000);
        observe(1, W1, 1'b0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, t1);
        chk("w3_rd_back", fb[1], 16'h9876);

        // Reset asserted mid-access (SETUP on the pins, strobe not yet low).
        drive_req(1, 1'b0, 1'b1, 16'h7777, 16'hCAFE);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ntw[1] = 1'b0;
        probe_en[1] = 1'b1;
        #1;
        chk("mid_rst_en", en[1], 1);
        chk("mid_rst_oe", oe[1], 1);
        chk("mid_rst_we", we[1], 1);
        chk("mid_rst_done", done[1], 0);
        chk("mid_rst_feedback", fb[1], 0);
        chk("mid_rst_ram_addr", radr[1], 0);
        chk("mid_rst_bus_released", bus1, 16'h0000);
        probe_en[1] = 1'b0;
        ref_fb[0] = 16'h0000;
        ref_fb[1] = 16'h0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic on both instances.
        for (int n = 0; n < 30; n++) begin
            i    = int'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 2));
            w    = (sel != 0);
            r    = (sel != 1);
            a    = ($urandom_range(0, 1) == 1) ? last_a[i] : 16'($urandom);
            d    = 16'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            drive_req(i, r, w, a, d);
            observe(i, (i == 0) ? W0 : W1, w, a, d, drop, 1'b0, t1);
            if (w) last_a[i] = a;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
